// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32I encoding definitions for the micro-op encoder.
//   op_e        : micro-op selector carried on in_op
//   OPC_*       : major opcodes used by the supported ops
//   F3_*        : funct3 values
//   IMM_*_MIN/MAX : signed immediate ranges accepted by the encoder
//   branch_f3() : op_e -> funct3 for the six conditional branches
package riscv_pkg;

   typedef enum logic [2:0] {
      OP_ADD  = 3'd0,
      OP_ADDI = 3'd1,
      OP_BEQ  = 3'd2,
      OP_BNE  = 3'd3,
      OP_BLT  = 3'd4,
      OP_BGE  = 3'd5,
      OP_BLTU = 3'd6,
      OP_BGEU = 3'd7
   } op_e;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   localparam int IMM_I_MIN = -2048;
   localparam int IMM_I_MAX = 2047;
   localparam int IMM_B_MIN = -4096;
   localparam int IMM_B_MAX = 4094;

   function automatic logic [2:0] branch_f3(input op_e op);
      logic [2:0] f3;
      f3 = F3_BEQ;
      case (op)
         OP_BNE:  f3 = F3_BNE;
         OP_BLT:  f3 = F3_BLT;
         OP_BGE:  f3 = F3_BGE;
         OP_BLTU: f3 = F3_BLTU;
         OP_BGEU: f3 = F3_BGEU;
         default: f3 = F3_BEQ;
      endcase
      return f3;
   endfunction

endpackage

// File: rtl/instr_field_pack.sv
// instr_field_pack: combinational RV32I field packer.
//   op      in  op_e   micro-op
//   rd      in  5      destination register (ADD/ADDI)
//   rs1     in  5      source register 1
//   rs2     in  5      source register 2 (ADD/branches)
//   imm     in  32     signed immediate / byte branch offset
//   instr   out 32     encoded instruction word
//   imm_ok  out 1      immediate fits the op's encodable range
module instr_field_pack
   import riscv_pkg::*;
(
   input  op_e         op,
   input  logic [4:0]  rd,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   input  logic [31:0] imm,
   output logic [31:0] instr,
   output logic        imm_ok
);

   logic signed [31:0] imm_s;
   assign imm_s = imm;

   always_comb begin
      instr  = '0;
      imm_ok = 1'b1;
      case (op)
         OP_ADD: begin
            instr = {7'b0, rs2, rs1, F3_ADD, rd, OPC_OP};
         end
         OP_ADDI: begin
            instr  = {imm[11:0], rs1, F3_ADD, rd, OPC_OPIMM};
            imm_ok = (imm_s >= IMM_I_MIN) && (imm_s <= IMM_I_MAX);
         end
         default: begin
            // B-type scatters the halfword offset; bit 0 is implied zero.
            instr  = {imm[12], imm[10:5], rs2, rs1, branch_f3(op),
                      imm[4:1], imm[11], OPC_BRANCH};
            imm_ok = (imm_s >= IMM_B_MIN) && (imm_s <= IMM_B_MAX) && !imm[0];
         end
      endcase
   end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: encodes ADD/ADDI/Bxx micro-ops into RV32I words and streams
// them with sequential word addresses toward instruction memory.
//   clk, rst              clock, synchronous active-high reset
//   in_valid/in_ready     micro-op handshake
//   in_op/in_rd/in_rs1/in_rs2/in_imm   micro-op fields
//   out_valid/out_ready   encoded-word handshake
//   out_instr/out_addr    encoded word and its word address
//   count                 words emitted since reset (saturates at capacity)
//   full                  count reached 2**ADDR_W
//   err_imm/err_op        sticky range error and op of the latest rejection
//   err_clr               clears err_imm (a same-cycle rejection wins)
module instr_encoder
   import riscv_pkg::*;
#(
   parameter int unsigned ADDR_W    = 8,
   parameter int unsigned BASE_ADDR = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        in_op,
   input  logic [4:0]        in_rd,
   input  logic [4:0]        in_rs1,
   input  logic [4:0]        in_rs2,
   input  logic [31:0]       in_imm,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_instr,
   output logic [ADDR_W-1:0] out_addr,
   output logic [ADDR_W:0]   count,
   output logic              full,
   output logic              err_imm,
   output logic [2:0]        err_op,
   input  logic              err_clr
);

   localparam logic [ADDR_W:0]   CAPACITY = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);

   logic [31:0]     packed_instr;
   logic            imm_ok;
   logic            accept;
   logic            out_fire;
   logic [ADDR_W:0] count_next;

   instr_field_pack u_pack (
      .op     (op_e'(in_op)),
      .rd     (in_rd),
      .rs1    (in_rs1),
      .rs2    (in_rs2),
      .imm    (in_imm),
      .instr  (packed_instr),
      .imm_ok (imm_ok)
   );

   assign full       = (count == CAPACITY);
   assign in_ready   = !full && (!out_valid || out_ready);
   assign accept     = in_valid && in_ready;
   assign out_fire   = out_valid && out_ready;
   assign count_next = full ? count : count + 1'b1;

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_instr <= '0;
         out_addr  <= BASE;
         count     <= '0;
         err_imm   <= 1'b0;
         err_op    <= '0;
      end else begin
         // out_addr always points at the next slot once the held word leaves,
         // so a same-cycle accept loads the correct address without a bubble.
         if (out_fire) begin
            count    <= count_next;
            out_addr <= BASE + count_next[ADDR_W-1:0];
         end

         if (accept && imm_ok) begin
            out_valid <= 1'b1;
            out_instr <= packed_instr;
         end else if (out_fire) begin
            out_valid <= 1'b0;
         end

         if (accept && !imm_ok) begin
            err_imm <= 1'b1;
            err_op  <= in_op;
         end else if (err_clr) begin
            err_imm <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;

   localparam int unsigned AW = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [2:0]    in_op;
   logic [4:0]    in_rd;
   logic [4:0]    in_rs1;
   logic [4:0]    in_rs2;
   logic [31:0]   in_imm;
   logic          out_valid;
   logic          out_ready;
   logic [31:0]   out_instr;
   logic [AW-1:0] out_addr;
   logic [AW:0]   count;
   logic          full;
   logic          err_imm;
   logic [2:0]    err_op;
   logic          err_clr;

   instr_encoder #(.ADDR_W(AW), .BASE_ADDR(0)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_op     (in_op),
      .in_rd     (in_rd),
      .in_rs1    (in_rs1),
      .in_rs2    (in_rs2),
      .in_imm    (in_imm),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_instr (out_instr),
      .out_addr  (out_addr),
      .count     (count),
      .full      (full),
      .err_imm   (err_imm),
      .err_op    (err_op),
      .err_clr   (err_clr)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] addr;
   } exp_t;

   exp_t        sb[$];
   int          checks   = 0;
   int          failures = 0;
   logic [31:0] cur_exp;
   logic        cur_ok;
   logic [31:0] exp_addr;

   function automatic logic [31:0] add_w(input int rd, input int rs1, input int rs2);
      return (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(rd) << 7) | 32'h33;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic put(input int op, input int rd, input int rs1, input int rs2,
                      input int imm, input logic [31:0] exp, input logic ok);
      in_valid = 1'b1;
      in_op    = 3'(op);
      in_rd    = 5'(rd);
      in_rs1   = 5'(rs1);
      in_rs2   = 5'(rs2);
      in_imm   = 32'(imm);
      cur_exp  = exp;
      cur_ok   = ok;
   endtask

   // One clock: score handshakes just before the edge, then step past it.
   task automatic tick();
      exp_t e;
      #1;
      if (out_valid && out_ready) begin
         if (sb.size() == 0) begin
            failures++;
            $error("FAIL sb_unexpected got=%h exp=none", out_instr);
         end else begin
            e = sb.pop_front();
            chk("sb_instr", out_instr, e.instr);
            chk("sb_addr", 32'(out_addr), e.addr);
         end
      end
      if (in_valid && in_ready && cur_ok) begin
         e.instr = cur_exp;
         e.addr  = exp_addr % (32'd1 << AW);
         sb.push_back(e);
         exp_addr++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      in_valid  = 1'b0;
      out_ready = 1'b0;
      err_clr   = 1'b0;
      rst       = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
      sb.delete();
      exp_addr = 0;
   endtask

   initial begin
      in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
      cur_exp = '0; cur_ok = 1'b0;
      do_reset();

      // reset state
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_out_instr", out_instr, 0);
      chk("rst_out_addr", 32'(out_addr), 0);
      chk("rst_count", 32'(count), 0);
      chk("rst_full", 32'(full), 0);
      chk("rst_err_imm", 32'(err_imm), 0);
      chk("rst_err_op", 32'(err_op), 0);
      chk("rst_in_ready", 32'(in_ready), 1);

      // basic ADD, then ADDI with negative immediate
      out_ready = 1'b1;
      put(0, 3, 1, 2, 0, 32'h002081B3, 1'b1);
      tick();
      in_valid = 1'b0;
      chk("add_out_valid", 32'(out_valid), 1);
      chk("add_out_addr", 32'(out_addr), 0);
      tick();
      chk("add_count", 32'(count), 1);
      chk("add_valid_drop", 32'(out_valid), 0);
      put(1, 5, 0, 0, -1, 32'hFFF00293, 1'b1);
      tick();
      in_valid = 1'b0;
      tick();
      chk("addi_count", 32'(count), 2);
      chk("addi_next_addr", 32'(out_addr), 2);

      // branch encodings, back to back
      do_reset();
      out_ready = 1'b1;
      put(2, 0, 1, 2, 8, 32'h00208463, 1'b1);
      tick();
      put(3, 0, 1, 2, -4, 32'hFE209EE3, 1'b1);
      tick();
      in_valid = 1'b0;
      tick();
      chk("br_count", 32'(count), 2);

      // immediate range checks and sticky error
      do_reset();
      out_ready = 1'b1;
      put(1, 5, 0, 0, 2048, 32'h0, 1'b0);
      tick();
      in_valid = 1'b0;
      chk("rej_addi_valid", 32'(out_valid), 0);
      chk("rej_addi_err", 32'(err_imm), 1);
      chk("rej_addi_op", 32'(err_op), 1);
      chk("rej_addi_count", 32'(count), 0);
      put(4, 0, 1, 2, 3, 32'h0, 1'b0);
      tick();
      chk("rej_blt_op", 32'(err_op), 4);
      chk("rej_blt_valid", 32'(out_valid), 0);
      put(1, 5, 0, 0, 2047, 32'h7FF00293, 1'b1);
      tick();
      put(5, 0, 1, 2, -4096, 32'h8020D063, 1'b1);
      tick();
      put(7, 0, 1, 2, 4096, 32'h0, 1'b0);
      err_clr = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("clr_vs_rej_err", 32'(err_imm), 1);
      chk("clr_vs_rej_op", 32'(err_op), 7);
      chk("rej_after_fire_valid", 32'(out_valid), 0);
      tick();
      err_clr = 1'b0;
      chk("clr_err", 32'(err_imm), 0);
      chk("rej_count", 32'(count), 2);

      // backpressure, then no-bubble streaming
      do_reset();
      put(0, 1, 1, 1, 0, add_w(1, 1, 1), 1'b1);
      tick();
      put(0, 2, 2, 2, 0, add_w(2, 2, 2), 1'b1);
      for (int i = 0; i < 3; i++) begin
         chk("bp_in_ready", 32'(in_ready), 0);
         chk("bp_hold_instr", out_instr, add_w(1, 1, 1));
         chk("bp_hold_addr", 32'(out_addr), 0);
         tick();
      end
      out_ready = 1'b1;
      tick();
      chk("stream_valid1", 32'(out_valid), 1);
      chk("stream_addr1", 32'(out_addr), 1);
      put(0, 7, 6, 5, 0, add_w(7, 6, 5), 1'b1);
      tick();
      chk("stream_valid2", 32'(out_valid), 1);
      in_valid = 1'b0;
      tick();
      chk("stream_drained", 32'(out_valid), 0);
      chk("stream_count", 32'(count), 3);

      // capacity with ADDR_W=2
      do_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         put(0, i + 4, i, i + 1, 0, add_w(i + 4, i, i + 1), 1'b1);
         tick();
      end
      in_valid = 1'b0;
      tick();
      chk("cap_full", 32'(full), 1);
      chk("cap_in_ready", 32'(in_ready), 0);
      chk("cap_count", 32'(count), 4);
      put(0, 1, 1, 1, 0, add_w(1, 1, 1), 1'b1);
      tick();
      in_valid = 1'b0;
      chk("cap_no_accept", 32'(out_valid), 0);
      chk("sb_empty", 32'(sb.size()), 0);

      // reset while a word is held
      do_reset();
      put(0, 9, 8, 7, 0, add_w(9, 8, 7), 1'b1);
      tick();
      in_valid = 1'b0;
      chk("hold_before_rst", 32'(out_valid), 1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      sb.delete();
      chk("mid_rst_valid", 32'(out_valid), 0);
      chk("mid_rst_instr", out_instr, 0);
      chk("mid_rst_addr", 32'(out_addr), 0);
      chk("mid_rst_count", 32'(count), 0);
      chk("mid_rst_full", 32'(full), 0);
      chk("mid_rst_err", 32'(err_imm), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
